// File: rtl/reset_pkg.sv
// Shared types and helpers for the multi-channel reset sequencer.
// Holds the sequencer state encoding and the next-channel priority pick.
package reset_pkg;

   localparam int MAX_CHANNELS = 16;

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      RELEASE
   } rst_state_t;

   // Index of the lowest set bit; returns 0 for an all-zero vector, so callers gate with the bit itself.
   function automatic logic [3:0] lowest_set_index(input logic [MAX_CHANNELS-1:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/reset_seq.sv
// Multi-channel reset sequencer: holds requested resets low for a minimum pulse,
// then releases them one by one in ascending order, queueing late requests.
module reset_seq
   import reset_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                in_clk,
   input  logic                in_rst,
   input  logic [CHANNELS-1:0] in_req_n,
   output logic [CHANNELS-1:0] out_rst_n,
   output logic                out_busy,
   output logic                out_done
);

   localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   rst_state_t          state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [CHANNELS-1:0] mask_reg, mask_next;
   logic [CHANNELS-1:0] pend_reg, pend_next;
   logic [CHANNELS-1:0] rst_n_reg, rst_n_next;
   logic                busy_reg, busy_next;
   logic                done_reg, done_next;

   logic [CHANNELS-1:0] req_vec;
   logic [CHANNELS-1:0] pick;
   logic [CHANNELS-1:0] start_set;
   logic [CHANNELS-1:0] new_req;
   logic [CHANNELS-1:0] late_req;
   logic [3:0]          low_idx;
   logic                pulse_hit;
   logic                gap_hit;

   assign req_vec = ~in_req_n;
   assign low_idx = lowest_set_index(MAX_CHANNELS'(mask_reg));

   // One-hot select of the next channel to release.
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_pick
         assign pick[gi] = mask_reg[gi] && (low_idx == 4'(gi));
      end
   endgenerate

   // The counter holds completed cycles since the start/restart (or last release) edge.
   assign pulse_hit = (cnt_reg == CNT_W'(PULSE_CYCLES - 1));
   assign gap_hit   = (cnt_reg == CNT_W'(GAP_CYCLES - 1));

   assign start_set = req_vec | pend_reg;
   assign new_req   = req_vec & ~mask_reg;
   assign late_req  = req_vec & ~mask_reg & ~pend_reg;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      mask_next  = mask_reg;
      pend_next  = pend_reg;
      rst_n_next = rst_n_reg;
      done_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start_set != '0) begin
               mask_next  = start_set;
               pend_next  = '0;
               rst_n_next = rst_n_reg & ~start_set;
               cnt_next   = '0;
               state_next = ASSERT;
            end
         end

         ASSERT: begin
            if (new_req != '0) begin
               // Joining channels extend the pulse for everyone.
               mask_next  = mask_reg | new_req;
               rst_n_next = rst_n_reg & ~new_req;
               cnt_next   = '0;
            end else if (pulse_hit) begin
               rst_n_next = rst_n_reg | pick;
               mask_next  = mask_reg & ~pick;
               cnt_next   = '0;
               if ((mask_reg & ~pick) == '0) begin
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = RELEASE;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         RELEASE: begin
            // Channels outside the mask go low now and wait for the next sequence.
            pend_next  = pend_reg | late_req;
            rst_n_next = rst_n_reg & ~late_req;
            if (gap_hit) begin
               rst_n_next = (rst_n_reg & ~late_req) | pick;
               mask_next  = mask_reg & ~pick;
               cnt_next   = '0;
               if ((mask_reg & ~pick) == '0) begin
                  done_next  = 1'b1;
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE) || (pend_next != '0);
   end

   always_ff @(posedge in_clk) begin
      if (!in_rst) begin
         state_reg <= ASSERT;
         cnt_reg   <= '0;
         mask_reg  <= '1;
         pend_reg  <= '0;
         rst_n_reg <= '0;
         busy_reg  <= 1'b1;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         mask_reg  <= mask_next;
         pend_reg  <= pend_next;
         rst_n_reg <= rst_n_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   assign out_rst_n = rst_n_reg;
   assign out_busy  = busy_reg;
   assign out_done  = done_reg;

endmodule
